// File: rtl/ble_uart_tx_if.sv
// Byte-push / status bundle for the ble_uart_tx UART 8N1 transmitter.
// master: the producer that queues bytes; slave: the transmitter itself.
interface ble_uart_tx_if;
    logic [7:0] tx_data;
    logic       trmt;
    logic       TX;
    logic       tx_done;
    logic       tx_busy;
    logic       fifo_full;
    logic       ovfl;

    modport master (
        output tx_data, trmt,
        input  TX, tx_done, tx_busy, fifo_full, ovfl
    );

    modport slave (
        input  tx_data, trmt,
        output TX, tx_done, tx_busy, fifo_full, ovfl
    );
endinterface

// File: rtl/ble_uart_tx.sv
// ble_uart_tx: UART 8N1 transmitter fed by a small circular FIFO.
// Bytes are sent LSB first, BAUD_DIV clocks per bit, TX idles high.
// Optional even-parity bit between data and stop: define BLE_UART_TX_PARITY_EN.
module ble_uart_tx #(
    parameter int BAUD_DIV = 2604,
    parameter int DEPTH    = 4
) (
    input logic         clk,
    input logic         rst,
    ble_uart_tx_if.slave bus
);
    localparam int BW = $clog2(BAUD_DIV);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
    localparam logic [CW-1:0] CNT_FULL  = CW'(DEPTH);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_STOP   = 3'd3;
`ifdef BLE_UART_TX_PARITY_EN
    localparam logic [2:0] ST_PARITY = 3'd4;
`endif

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          full_q, ovfl_q, ovfl_d;
    logic [2:0]    state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          tx_q, tx_d, done_q, done_d;
`ifdef BLE_UART_TX_PARITY_EN
    logic          parity_q, parity_d;
`endif

    logic       push_s, pop_s, empty_s, full_s, baud_last_s;
    logic [7:0] head_s;

    assign full_s      = (count_q == CNT_FULL);
    assign empty_s     = (count_q == {CW{1'b0}});
    assign push_s      = bus.trmt && !full_s;
    assign head_s      = mem_q[rptr_q];
    assign baud_last_s = (baud_q == BAUD_LAST);

    assign bus.TX        = tx_q;
    assign bus.tx_done   = done_q;
    assign bus.fifo_full = full_q;
    assign bus.ovfl      = ovfl_q;
    assign bus.tx_busy   = (state_q != ST_IDLE) || !empty_s;

    // Frame sequencer: bit timing, shifting and FIFO pops.
    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        pop_s    = 1'b0;
`ifdef BLE_UART_TX_PARITY_EN
        parity_d = parity_q;
`endif
        case (state_q)
            ST_IDLE: begin
                baud_d = {BW{1'b0}};
                bit_d  = 3'd0;
                if (!empty_s) begin
                    pop_s    = 1'b1;
                    shift_d  = head_s;
                    state_d  = ST_START;
`ifdef BLE_UART_TX_PARITY_EN
                    parity_d = ^head_s;
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                if (baud_last_s) begin
                    baud_d  = {BW{1'b0}};
                    bit_d   = 3'd0;
                    state_d = ST_DATA;
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            ST_DATA: begin
                if (baud_last_s) begin
                    baud_d  = {BW{1'b0}};
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
                        bit_d   = 3'd0;
`ifdef BLE_UART_TX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
`ifdef BLE_UART_TX_PARITY_EN
            ST_PARITY: begin
                if (baud_last_s) begin
                    baud_d  = {BW{1'b0}};
                    state_d = ST_STOP;
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
`endif
            ST_STOP: begin
                if (baud_last_s) begin
                    baud_d = {BW{1'b0}};
                    if (!empty_s) begin
                        pop_s    = 1'b1;
                        shift_d  = head_s;
                        state_d  = ST_START;
`ifdef BLE_UART_TX_PARITY_EN
                        parity_d = ^head_s;
`endif
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                baud_d  = {BW{1'b0}};
                bit_d   = 3'd0;
            end
        endcase
    end

    // Line level and done pulse computed from the next state so both come straight from flops.
    always_comb begin
        case (state_d)
            ST_IDLE:   tx_d = 1'b1;
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = shift_d[0];
`ifdef BLE_UART_TX_PARITY_EN
            ST_PARITY: tx_d = parity_d;
`endif
            ST_STOP:   tx_d = 1'b1;
            default:   tx_d = 1'b1;
        endcase
        done_d = (state_d == ST_STOP) && (baud_d == BAUD_LAST);
    end

    // FIFO bookkeeping: pointers, occupancy and sticky overflow.
    always_comb begin
        wptr_d = push_s ? (wptr_q + AW'(1)) : wptr_q;
        rptr_d = pop_s  ? (rptr_q + AW'(1)) : rptr_q;
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        ovfl_d = ovfl_q || (bus.trmt && full_s);
    end

    // FIFO storage; contents need no reset because occupancy gates every read.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wptr_q] <= bus.tx_data;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            baud_q   <= {BW{1'b0}};
            bit_q    <= 3'd0;
            shift_q  <= 8'h00;
            wptr_q   <= {AW{1'b0}};
            rptr_q   <= {AW{1'b0}};
            count_q  <= {CW{1'b0}};
            full_q   <= 1'b0;
            ovfl_q   <= 1'b0;
            tx_q     <= 1'b1;
            done_q   <= 1'b0;
`ifdef BLE_UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            count_q  <= count_d;
            full_q   <= (count_d == CNT_FULL);
            ovfl_q   <= ovfl_d;
            tx_q     <= tx_d;
            done_q   <= done_d;
`ifdef BLE_UART_TX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end
endmodule

// File: doc/ble_uart_tx.md
Name: ble_uart_tx

Overview:
- UART 8N1 transmitter with a small input FIFO. It is the transmit end of the serial link whose receiver feeds the authentication block.
- Used as the BLE-side stimulus source in fullchip benches and as a diagnostics/telemetry transmitter in the digital core.
- Serialises queued bytes onto TX, LSB first, at a fixed bit period.

Parameters:
- BAUD_DIV, 2604: clk cycles per bit (50 MHz / 19200). Legal range 4..4095.
- DEPTH, 4: FIFO entries. Power of 2, range 2..16.

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous active-high reset
- tx_data  in  8  byte to queue
- trmt  in  1  one-cycle push strobe; tx_data sampled on the same edge
- TX  out  1  serial line, idle high
- tx_done  out  1  one-cycle pulse when a stop bit completes
- tx_busy  out  1  high while the FSM is not IDLE or the FIFO is non-empty
- fifo_full  out  1  high when the FIFO holds DEPTH bytes
- ovfl  out  1  sticky; set when trmt arrives while fifo_full; cleared only by rst

Behaviour:
- Everything is reset synchronously by rst:
  - TX=1; tx_done=0; tx_busy=0; fifo_full=0; ovfl=0.
  - FIFO pointers and count=0; FSM=IDLE; baud counter=0; bit counter=0.
- rst asserted mid-frame: TX returns high on the next edge, the queued bytes are discarded, and tx_done does not pulse.
- FIFO:
  - Circular buffer with registered count.
  - A push with trmt while not full writes at the write pointer. Pointers wrap modulo DEPTH.
  - trmt while fifo_full drops the byte and sets ovfl, even if a pop occurs in the same cycle.
  - Push and pop in the same cycle (not full) leave count unchanged.
- FSM states: IDLE, START, DATA, STOP.
- IDLE:
  - If count>0, pop the head into the shift register and go to START.
  - TX falls on the cycle after the pop.
  - With an empty FIFO and idle FSM, trmt at cycle 0 gives TX=0 from cycle 2.
- START: TX=0 for BAUD_DIV cycles, then DATA.
- DATA:
  - TX = shift[0] for BAUD_DIV cycles per bit; then shift right.
  - Bit counter runs 0..7; after bit 7 go to STOP.
- STOP: TX=1 for BAUD_DIV cycles.
- On the last STOP cycle:
  - Assert tx_done for that cycle.
  - If count>0: pop and go to START, so the next start bit begins on the following cycle with zero idle gap.
  - Otherwise go to IDLE.
- Baud counter:
  - Counts 0..BAUD_DIV-1 and reloads to 0 at each bit boundary.
  - Forced to 0 in IDLE.
  - Width is clog2(BAUD_DIV).
- Frame length is exactly 10*BAUD_DIV cycles, or 11*BAUD_DIV with parity.
- TX is driven from a register, glitch-free.
- tx_busy is combinational from FSM state and count.

Optional Feature:
- Macro: BLE_UART_TX_PARITY_EN.
- Defined:
  - Adds state PARITY between DATA and STOP.
  - TX = XOR of the 8 data bits (even parity) for BAUD_DIV cycles.
  - Frame is 11*BAUD_DIV cycles; tx_done moves accordingly.
- Undefined: no PARITY state and no parity logic; frame is 10*BAUD_DIV.

Test Plan:
- Single byte, BAUD_DIV=4: rst then trmt with tx_data=8'hA5 at cycle 0.
  - Required: TX=0 on cycles 2-5.
  - Then bits 1,0,1,0,0,1,0,1, each 4 cycles, on cycles 6-37.
  - Stop high on cycles 38-41; tx_done high on cycle 41 only.
- Back-to-back: push 8'h00, 8'hFF, 8'h3C in consecutive cycles.
  - Required: three frames with no idle cycle between the stop of one and the start of the next.
  - Three tx_done pulses 40 cycles apart; tx_busy falls the cycle after the third.
- Overflow, DEPTH=4, BAUD_DIV=4: push 6 bytes in consecutive cycles starting from idle.
  - Required: fifo_full asserts when 4 bytes are queued.
  - The 6th byte is dropped, ovfl=1, and exactly 5 frames are transmitted in order.
- Reset mid-frame: assert rst during DATA bit 3 of 8'h5A.
  - Required: TX=1 on the next edge, no tx_done, FIFO empty.
  - A subsequent push of 8'h81 transmits correctly.
- Parity with BLE_UART_TX_PARITY_EN defined:
  - 8'h07 gives parity bit 1; 8'h03 gives parity bit 0.
  - Frame is 44 cycles at BAUD_DIV=4.
- Large divider, BAUD_DIV=2604: send 8'h55.
  - Required: each bit lasts exactly 2604 cycles; total frame is 26040 cycles.
